// File: rtl/core_op_driver_if.sv
// Bundle of the command, image-memory, core and result signals of core_op_driver.
// master: the driver side; slave: the environment (controller, memory and core).
interface core_op_driver_if;
    logic        i_cmd_valid;
    logic [3:0]  i_cmd_mode;
    logic        o_cmd_ready;
    logic        o_img_rd;
    logic [10:0] o_img_addr;
    logic [7:0]  i_img_data;
    logic        i_op_ready;
    logic        o_op_valid;
    logic [3:0]  o_op_mode;
    logic        i_in_ready;
    logic        o_in_valid;
    logic [7:0]  o_in_data;
    logic        i_out_valid;
    logic [13:0] i_out_data;
    logic        o_res_valid;
    logic [13:0] o_res_data;
    logic [9:0]  o_res_count;
    logic        o_busy;
    logic        o_done;
    logic [2:0]  o_err;

    modport master (
        input  i_cmd_valid, i_cmd_mode, i_img_data, i_op_ready, i_in_ready,
        input  i_out_valid, i_out_data,
        output o_cmd_ready, o_img_rd, o_img_addr, o_op_valid, o_op_mode, o_in_valid,
        output o_in_data, o_res_valid, o_res_data, o_res_count, o_busy, o_done, o_err
    );

    modport slave (
        output i_cmd_valid, i_cmd_mode, i_img_data, i_op_ready, i_in_ready,
        output i_out_valid, i_out_data,
        input  o_cmd_ready, o_img_rd, o_img_addr, o_op_valid, o_op_mode, o_in_valid,
        input  o_in_data, o_res_valid, o_res_data, o_res_count, o_busy, o_done, o_err
    );
endinterface

// File: rtl/core_op_driver.sv
// Host-side initiator for the image core: queues op commands, issues them on the
// op handshake, streams the image for LOAD ops and collects results for the rest.
// Optional watchdog enabled by defining CORE_OP_DRIVER_TIMEOUT_EN.
module core_op_driver #(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned IMG_BYTES = 2048,
    parameter int unsigned TIMEOUT   = 4095
) (
    input logic             i_clk,
    input logic             i_rst_n,
    core_op_driver_if.master bus
);

    localparam int unsigned PtrW = $clog2(CMD_DEPTH);
    localparam int unsigned CntW = $clog2(IMG_BYTES) + 1;
    localparam logic [CntW-1:0] ImgEnd  = CntW'(IMG_BYTES);
    localparam logic [CntW-1:0] ImgLast = CntW'(IMG_BYTES - 1);
    localparam logic [PtrW:0]   FifoMax = (PtrW + 1)'(CMD_DEPTH);

    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("CMD_DEPTH must be a power of 2 and at least 2");
    end
    if (IMG_BYTES < 2 || IMG_BYTES > 2048) begin : g_bad_img
        $error("IMG_BYTES must lie in 2..2048");
    end
    if (TIMEOUT < 2 || TIMEOUT > 4095) begin : g_bad_timeout
        $error("TIMEOUT must fit the 12-bit watchdog");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StLoad, StRun} state_e;

    state_e          state_q, state_d;
    logic [3:0]      fifo_mem [CMD_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   fifo_cnt_q;
    logic            fifo_full, fifo_empty, push, pop;
    logic [3:0]      head;
    logic            illegal, done_set, abort, timeout_hit;
    logic            rdy_seen_q;
    logic [3:0]      mode_q;
    logic            op_valid_q, busy_q, done_q, res_valid_q;
    logic [13:0]     res_data_q;
    logic [9:0]      res_cnt_q;
    logic [2:0]      err_q;
    // Image stream: output register plus a one-entry skid for read data in flight.
    logic [CntW-1:0] rd_addr_q, beat_cnt_q;
    logic            rd_pend_q, out_v_q, skid_v_q;
    logic [7:0]      out_data_q, skid_data_q;
    logic            out_v_d, skid_v_d;
    logic [7:0]      out_data_d, skid_data_d;
    logic            accept, loading, img_rd, last_accept;
    logic [1:0]      slots_used;

    assign fifo_full  = (fifo_cnt_q == FifoMax);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign push       = bus.i_cmd_valid & ~fifo_full;
    assign head       = fifo_mem[rd_ptr_q];

    // Command FIFO storage, written at the tail on an accepted push.
    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.i_cmd_mode;
    end

    // Command FIFO pointers and occupancy; simultaneous push and pop both take effect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            fifo_cnt_q <= fifo_cnt_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
        end
    end

`ifdef CORE_OP_DRIVER_TIMEOUT_EN
    logic [11:0] wdog_q;
    logic        in_op;
    assign in_op       = (state_q == StLoad) || (state_q == StRun);
    assign timeout_hit = in_op && (wdog_q == 12'(TIMEOUT - 1));

    // Watchdog: restarts in ISSUE, counts every LOAD/RUN cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wdog_q <= '0;
        end else if (state_q == StIssue) begin
            wdog_q <= '0;
        end else if (in_op && wdog_q != 12'hfff) begin
            wdog_q <= wdog_q + 12'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // A real completion in the same cycle beats the watchdog.
    assign abort = timeout_hit & ~((state_q == StRun) & bus.i_op_ready);

    // Op sequencing: pop/validate in IDLE, one ISSUE cycle, then LOAD and/or RUN.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        illegal  = 1'b0;
        done_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rdy_seen_q && !fifo_empty) begin
                    pop = 1'b1;
                    if (head > 4'd10) illegal = 1'b1;
                    else              state_d = StIssue;
                end
            end
            StIssue: state_d = (mode_q == 4'd0) ? StLoad : StRun;
            StLoad:  if (last_accept) state_d = StRun;
            StRun: begin
                if (bus.i_op_ready) begin
                    state_d  = StIdle;
                    done_set = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d  = StIdle;
            done_set = 1'b1;
        end
    end

    // FSM state and op-level registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            rdy_seen_q  <= 1'b0;
            mode_q      <= '0;
            op_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_cnt_q   <= '0;
            err_q       <= '0;
        end else begin
            state_q <= state_d;
            if (bus.i_op_ready || abort) rdy_seen_q <= 1'b1;
            else if (state_q == StIssue) rdy_seen_q <= 1'b0;
            if (pop && !illegal) mode_q <= head;
            op_valid_q  <= (state_d == StIssue);
            busy_q      <= (state_d != StIdle);
            done_q      <= done_set;
            res_valid_q <= (state_q == StRun) && bus.i_out_valid;
            if ((state_q == StRun) && bus.i_out_valid) res_data_q <= bus.i_out_data;
            if (state_d == StIssue) begin
                res_cnt_q <= '0;
            end else if ((state_q == StRun) && bus.i_out_valid && res_cnt_q != 10'h3ff) begin
                res_cnt_q <= res_cnt_q + 10'd1;
            end
            err_q[0] <= err_q[0] | abort;
            err_q[1] <= err_q[1] | (bus.i_out_valid && state_q != StRun);
            err_q[2] <= err_q[2] | illegal;
        end
    end

    assign accept      = out_v_q & bus.i_in_ready;
    assign last_accept = (state_q == StLoad) && accept && (beat_cnt_q == ImgLast);
    // Reads start in the ISSUE cycle so the first beat appears two cycles later.
    assign loading     = (state_q == StLoad) || ((state_q == StIssue) && (mode_q == 4'd0));
    // Slots still held after this cycle; a new read needs one free slot next cycle.
    assign slots_used  = 2'(out_v_q) + 2'(skid_v_q) + 2'(rd_pend_q) - 2'(accept);
    assign img_rd      = loading && (rd_addr_q != ImgEnd) && (slots_used <= 2'd1) && !abort;

    // Output/skid steering: refill the output from skid first, else from arriving data.
    always_comb begin
        out_v_d     = out_v_q;
        out_data_d  = out_data_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        if (!out_v_q || accept) begin
            if (skid_v_q) begin
                out_v_d     = 1'b1;
                out_data_d  = skid_data_q;
                skid_v_d    = rd_pend_q;
                skid_data_d = bus.i_img_data;
            end else if (rd_pend_q) begin
                out_v_d    = 1'b1;
                out_data_d = bus.i_img_data;
            end else begin
                out_v_d = 1'b0;
            end
        end else if (rd_pend_q) begin
            skid_v_d    = 1'b1;
            skid_data_d = bus.i_img_data;
        end
    end

    // Image stream registers; everything in flight is discarded outside an op.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_addr_q   <= '0;
            beat_cnt_q  <= '0;
            rd_pend_q   <= 1'b0;
            out_v_q     <= 1'b0;
            out_data_q  <= '0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
        end else if (state_q == StIdle || abort) begin
            rd_addr_q  <= '0;
            beat_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            out_v_q    <= 1'b0;
            skid_v_q   <= 1'b0;
        end else begin
            rd_addr_q   <= rd_addr_q + CntW'(img_rd);
            beat_cnt_q  <= beat_cnt_q + CntW'(accept);
            rd_pend_q   <= img_rd;
            out_v_q     <= out_v_d;
            out_data_q  <= out_data_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign bus.o_cmd_ready = ~fifo_full;
    assign bus.o_img_rd    = img_rd;
    assign bus.o_img_addr  = 11'(rd_addr_q);
    assign bus.o_op_valid  = op_valid_q;
    assign bus.o_op_mode   = mode_q;
    assign bus.o_in_valid  = out_v_q;
    assign bus.o_in_data   = out_data_q;
    assign bus.o_res_valid = res_valid_q;
    assign bus.o_res_data  = res_data_q;
    assign bus.o_res_count = res_cnt_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;

endmodule

// File: doc/core_op_driver.md
Name: core_op_driver

Overview:
- Host-side initiator for the image-processing core's op/data/result interface.
- Accepts queued operation commands and issues each one to the core on an op_valid/op_mode handshake.
- For a load operation, streams the 2048-byte image from an external byte memory.
- For other operations, collects the core's result stream and reports it upstream.
- Sits between the system controller and the core, and replaces hand-driven stimulus in integration.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of 2, min 2).
- IMG_BYTES, 2048, bytes streamed per load op.
- TIMEOUT, 4095, max cycles from op issue to the core's op_ready before a timeout error is flagged.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_cmd_valid  in  1  command push request.
- i_cmd_mode  in  4  op code to queue.
- o_cmd_ready  out  1  FIFO not full; push accepted when valid&ready.
- o_img_rd  out  1  image memory read strobe.
- o_img_addr  out  11  image byte address.
- i_img_data  in  8  read data, valid exactly 1 cycle after o_img_rd.
- i_op_ready  in  1  core op_ready; a 1-cycle pulse.
- o_op_valid  out  1  op issue strobe to core.
- o_op_mode  out  4  op code to core.
- i_in_ready  in  1  core in_ready.
- o_in_valid  out  1  image byte valid to core.
- o_in_data  out  8  image byte to core.
- i_out_valid  in  1  core result valid.
- i_out_data  in  14  core result.
- o_res_valid  out  1  registered copy of accepted result.
- o_res_data  out  14  registered result.
- o_res_count  out  10  results received for the current op.
- o_busy  out  1  an op is in flight.
- o_done  out  1  1-cycle pulse when the in-flight op completes.
- o_err  out  3  sticky error flags: [0] timeout, [1] unexpected out_valid, [2] illegal op code.

Behaviour:
- Interface: i_clk drives all logic. Reset i_rst_n is asynchronous and active-low.
- Reset values: all outputs 0 except o_cmd_ready=1. FIFO empty, rdy_seen=0, state IDLE.
- Reset mid-operation aborts immediately. No further o_op_valid or o_in_valid is driven.
- Op codes:
  - 0 = LOAD.
  - 1..6 = immediate ops (shift R/L/U/D, reduce, increase).
  - 7 = display, 8 = conv, 9 = median, 10 = sobel-NMS.
  - 11..15 are illegal.
- rdy_seen flag: set by i_op_ready in any state. Cleared in the ISSUE cycle.
- A core op_ready arriving while rdy_seen is already 1 is absorbed (no error).
- IDLE state:
  - If rdy_seen=1 and the FIFO is not empty, pop one entry.
  - Illegal op code: drop it, set o_err[2], stay in IDLE.
  - Legal op code: go to ISSUE.
- ISSUE state (1 cycle):
  - o_op_valid=1 and o_op_mode=entry, registered outputs.
  - o_res_count cleared, o_busy=1.
  - Next state is LOAD for op 0, otherwise RUN.
- LOAD state:
  - Stream bytes at addresses 0..IMG_BYTES-1 ascending, one byte per o_in_valid beat.
  - A beat is accepted when o_in_valid & i_in_ready.
  - o_in_valid first rises no later than 2 cycles after the ISSUE cycle.
  - Throughput is 1 byte/cycle while i_in_ready=1.
  - When i_in_ready=0, o_in_data and o_in_valid are held stable. Prefetched read data must not be lost (1-entry skid).
  - o_img_rd is never asserted for an address ≥ IMG_BYTES.
  - After the last beat is accepted, o_in_valid=0 and the state goes to RUN.
- RUN state:
  - Each i_out_valid produces o_res_valid=1 and o_res_data=i_out_data on the next cycle. o_res_count increments (saturates at 1023).
  - On i_op_ready: o_done pulses 1 cycle, o_busy drops, state returns to IDLE with rdy_seen=1.
  - If i_op_ready and i_out_valid occur in the same cycle, the result is captured and then the op completes.
- i_out_valid in IDLE/ISSUE/LOAD: result is dropped and o_err[1] is set.
- Immediate ops (1..6) get no results. Completion is the next i_op_ready.
- Command FIFO:
  - o_cmd_ready = !full. Push while full is ignored.
  - Push and pop in the same cycle are both honoured.
  - Entries are issued in order.
- o_err bits clear only on reset.

Optional Feature:
- Macro: CORE_OP_DRIVER_TIMEOUT_EN.
- Defined:
  - A 12-bit watchdog counts cycles in LOAD+RUN, restarting at ISSUE.
  - On reaching TIMEOUT without i_op_ready, set o_err[0], pulse o_done, and force rdy_seen=1.
  - Then return to IDLE with o_in_valid=0.
- Undefined: no watchdog. o_err[0] is tied to 0, and the driver waits indefinitely.

Test Plan:
- Reset, core pulses op_ready, push cmd 0 with in_ready held 1 -> one o_op_valid with mode 0; bytes addr 0..2047 in order, 2048 consecutive beats; o_done after core op_ready.
- LOAD with in_ready toggled 0/1 every 3 cycles -> no byte dropped or duplicated; data at each accepted beat equals img[addr] for all 2048 bytes.
- Push cmds 2,9 back-to-back, core returns op_ready for op 2 and 16 results for op 9 -> ops issued in order; o_res_count=16; o_done pulses twice.
- Push 4 cmds then a 5th while full -> o_cmd_ready=0 and the 5th is not issued; push cmd 12 -> no op_valid, o_err=3'b100.
- i_out_valid pulsed while IDLE -> o_err[1]=1, no o_res_valid.
- With macro defined and TIMEOUT=50, issue cmd 8 with no op_ready -> o_err[0]=1 at cycle 50, o_done pulse, next command issues.
